// File: rtl/iob_picorv32_bus_arb_pkg.sv
// Shared types and width helpers for the picorv32 ibus/dbus arbiter.
package iob_picorv32_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_e;

  // Master identifiers used for owner / last_gnt / grant select.
  localparam logic MST_IBUS = 1'b0;
  localparam logic MST_DBUS = 1'b1;

  // Request bus {avalid, addr, wdata, wstrb}.
  function automatic int unsigned req_width(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response bus {rdata, rvalid, ready}.
  function automatic int unsigned resp_width(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/iob_picorv32_bus_arb_grant.sv
// Two-input grant: fixed dbus priority, or round-robin against last_gnt.
module iob_picorv32_bus_arb_grant
  import iob_picorv32_bus_arb_pkg::*;
#(
  parameter int unsigned RR_EN = 0
) (
  input  logic ibus_valid_i,
  input  logic dbus_valid_i,
  input  logic last_gnt_i,
  output logic gnt_valid_o,
  output logic gnt_sel_o
);

  // Pick the single requester, or resolve contention by policy.
  always_comb begin
    gnt_valid_o = ibus_valid_i | dbus_valid_i;
    gnt_sel_o   = MST_IBUS;
    if (ibus_valid_i && dbus_valid_i) begin
      gnt_sel_o = (RR_EN != 0) ? ~last_gnt_i : MST_DBUS;
    end else if (dbus_valid_i) begin
      gnt_sel_o = MST_DBUS;
    end
  end

endmodule

// File: rtl/iob_picorv32_bus_arb.sv
// 2:1 IOb arbiter merging picorv32 ibus and dbus onto one memory port,
// with at most one outstanding read routed back to its issuer.
module iob_picorv32_bus_arb
  import iob_picorv32_bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR_EN  = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cke_i,
  input  logic [req_width(ADDR_W, DATA_W)-1:0]  ibus_req_i,
  output logic [resp_width(DATA_W)-1:0]         ibus_resp_o,
  input  logic [req_width(ADDR_W, DATA_W)-1:0]  dbus_req_i,
  output logic [resp_width(DATA_W)-1:0]         dbus_resp_o,
  output logic [req_width(ADDR_W, DATA_W)-1:0]  mem_req_o,
  input  logic [resp_width(DATA_W)-1:0]         mem_resp_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned REQ_W  = req_width(ADDR_W, DATA_W);
  localparam int unsigned RESP_W = resp_width(DATA_W);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;

  logic              ibus_avalid, dbus_avalid;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              win_valid, win_sel;
  logic              arb_en, fwd, sel, sel_read, accept, rsp_valid;
  logic [REQ_W-1:0]  sel_req;

  assign ibus_avalid = ibus_req_i[REQ_W-1];
  assign dbus_avalid = dbus_req_i[REQ_W-1];
  assign mem_ready   = mem_resp_i[0];
  assign mem_rvalid  = mem_resp_i[1];
  assign mem_rdata   = mem_resp_i[RESP_W-1:2];

  iob_picorv32_bus_arb_grant #(
    .RR_EN(RR_EN)
  ) u_grant (
    .ibus_valid_i(ibus_avalid),
    .dbus_valid_i(dbus_avalid),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (win_valid),
    .gnt_sel_o   (win_sel)
  );

  // Select the forwarded master and compute the next state.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    fwd        = 1'b0;
    sel        = owner_q;

    // A returning read frees the port in the same cycle, so arbitrate then too.
    arb_en = (state_q == ST_IDLE) || ((state_q == ST_RD_WAIT) && mem_rvalid);

    if (arb_en) begin
      fwd = win_valid;
      sel = win_sel;
    end else if (state_q == ST_HOLD) begin
      fwd = (owner_q == MST_DBUS) ? dbus_avalid : ibus_avalid;
      sel = owner_q;
    end

    fwd       = fwd & ~rst_i;
    sel_req   = (sel == MST_DBUS) ? dbus_req_i : ibus_req_i;
    sel_read  = (sel_req[STRB_W-1:0] == '0);
    accept    = fwd & mem_ready;
    rsp_valid = ~rst_i & (state_q == ST_RD_WAIT) & mem_rvalid;

    if (accept) begin
      last_gnt_d = sel;
      owner_d    = sel;
      state_d    = sel_read ? ST_RD_WAIT : ST_IDLE;
    end else if (fwd) begin
      owner_d = sel;
      state_d = ST_HOLD;
    end else if ((state_q != ST_RD_WAIT) || mem_rvalid) begin
      state_d = ST_IDLE;
    end
  end

  // Drive the merged request and per-master responses.
  always_comb begin
    mem_req_o   = fwd ? sel_req : '0;
    ibus_resp_o = {mem_rdata, rsp_valid & (owner_q == MST_IBUS), accept & (sel == MST_IBUS)};
    dbus_resp_o = {mem_rdata, rsp_valid & (owner_q == MST_DBUS), accept & (sel == MST_DBUS)};
  end

  // State registers; cke_i freezes them while forwarding stays live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= MST_IBUS;
      last_gnt_q <= MST_IBUS;
    end else if (cke_i) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule
